// File: rtl/ex_mem_pkg.sv
// Shared types and width defaults for the EX->MEM pipeline boundary.
package ex_mem_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefMemopW = 4;
  localparam int unsigned DefCntW   = 16;

  typedef enum logic [DefMemopW-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } memop_e;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } skid_state_e;

  // Field order here is the bit order used when the top packs its ports.
  typedef struct packed {
    logic [DefAddrW-1:0]  waddr;
    logic                 we;
    logic [DefDataW-1:0]  wdata;
    logic [DefMemopW-1:0] mem_op;
    logic [DefDataW-1:0]  mem_addr;
    logic [DefDataW-1:0]  mem_sdata;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main entry M drives the output, skid entry S absorbs one
// overflow beat so the upstream ready is a registered signal.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned PAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [PAY_W-1:0] m_q, m_d;
  logic [PAY_W-1:0] s_q, s_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = StEmpty;
      m_d     = '0;
      s_d     = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            m_d     = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            m_d = in_data;
          end else if (in_xfer) begin
            s_d     = in_data;
            state_d = StTwo;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        // in_ready is low here, so no upstream beat can arrive.
        StTwo: begin
          if (out_xfer) begin
            m_d     = s_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Both handshake outputs decode only the state flop; no path from out_ready.
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
    out_data  = m_q;
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM boundary with valid/ready handshake, skid buffering, flush and a
// saturating backpressure counter.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned MEMOP_W = DefMemopW,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [ADDR_W-1:0]  ex_waddr,
  input  logic               ex_we,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [MEMOP_W-1:0] ex_mem_op,
  input  logic [DATA_W-1:0]  ex_mem_addr,
  input  logic [DATA_W-1:0]  ex_mem_sdata,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [MEMOP_W-1:0] mem_op,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_sdata,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PayW = ADDR_W + 1 + DATA_W + MEMOP_W + DATA_W + DATA_W;

  logic [PayW-1:0]  in_pay, out_pay;
  logic             mem_we_raw;
  logic [CNT_W-1:0] stall_cnt_q;

  // Same field order as ex_mem_payload_t, kept flat so non-default widths work.
  assign in_pay = {ex_waddr, ex_we, ex_wdata, ex_mem_op, ex_mem_addr, ex_mem_sdata};

  pipe_skid_buf #(
    .PAY_W(PayW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (ex_valid),
    .in_ready (ex_ready),
    .in_data  (in_pay),
    .out_valid(mem_valid),
    .out_ready(mem_ready),
    .out_data (out_pay)
  );

  assign {mem_waddr, mem_we_raw, mem_wdata, mem_op, mem_addr, mem_sdata} = out_pay;
  assign mem_we = mem_we_raw & mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (mem_valid && !mem_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: directed scenarios plus randomized valid/ready.
module tb_ex_mem_skid;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, mem_ready;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata, ex_mem_addr, ex_mem_sdata;
  logic [3:0]  ex_mem_op;

  logic        ex_ready, mem_valid, mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_addr, mem_sdata;
  logic [3:0]  mem_op;
  logic [15:0] stall_cnt;

  // Second instance with a 3-bit counter, driven identically, to see saturation.
  logic        s_ex_ready, s_mem_valid, s_mem_we;
  logic [4:0]  s_mem_waddr;
  logic [31:0] s_mem_wdata, s_mem_addr, s_mem_sdata;
  logic [3:0]  s_mem_op;
  logic [2:0]  s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_payload_t sb[$];
  ex_mem_payload_t last_pay;
  int              exp_stall, exp_stall_s;
  bit              chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_mem_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op),
    .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata), .stall_cnt(stall_cnt)
  );

  ex_mem_skid #(
    .CNT_W(3)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op),
    .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata), .mem_valid(s_mem_valid),
    .mem_ready(mem_ready), .mem_waddr(s_mem_waddr), .mem_we(s_mem_we),
    .mem_wdata(s_mem_wdata), .mem_op(s_mem_op), .mem_addr(s_mem_addr),
    .mem_sdata(s_mem_sdata), .stall_cnt(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay(input ex_mem_payload_t p);
    ex_waddr     = p.waddr;
    ex_we        = p.we;
    ex_wdata     = p.wdata;
    ex_mem_op    = p.mem_op;
    ex_mem_addr  = p.mem_addr;
    ex_mem_sdata = p.mem_sdata;
  endtask

  function automatic ex_mem_payload_t mk_pay(input logic [31:0] d);
    ex_mem_payload_t p;
    p.waddr     = d[4:0];
    p.we        = 1'b1;
    p.wdata     = d;
    p.mem_op    = MEM_LW;
    p.mem_addr  = d << 2;
    p.mem_sdata = ~d;
    return p;
  endfunction

  function automatic ex_mem_payload_t rand_pay();
    ex_mem_payload_t p;
    p.waddr     = 5'($urandom);
    p.we        = 1'($urandom);
    p.wdata     = $urandom;
    p.mem_op    = 4'($urandom);
    p.mem_addr  = $urandom;
    p.mem_sdata = $urandom;
    return p;
  endfunction

  // Compare outputs against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    ex_mem_payload_t shown, dut_pay, cur_pay, popped;
    bit accept;
    if (chk_en) begin
      shown = (sb.size() != 0) ? sb[0] : last_pay;
      check_eq("ex_ready", ex_ready, sb.size() < 2);
      check_eq("mem_valid", mem_valid, sb.size() != 0);
      check_eq("mem_we", mem_we, (sb.size() != 0) && shown.we);
      dut_pay = '{waddr: mem_waddr, we: 1'b0, wdata: mem_wdata, mem_op: mem_op,
                  mem_addr: mem_addr, mem_sdata: mem_sdata};
      shown.we = 1'b0;
      check_eq("payload", dut_pay, shown);
      check_eq("stall_cnt", stall_cnt, exp_stall);
      check_eq("stall_cnt_sat", s_stall_cnt, exp_stall_s);
    end
    if (rst) begin
      sb.delete();
      last_pay    = '0;
      exp_stall   = 0;
      exp_stall_s = 0;
      chk_en      = 1'b1;
    end else if (chk_en) begin
      if (sb.size() != 0 && !mem_ready) begin
        if (exp_stall != 65535) exp_stall++;
        if (exp_stall_s != 7) exp_stall_s++;
      end
      if (flush) begin
        sb.delete();
        last_pay = '0;
      end else begin
        cur_pay = '{waddr: ex_waddr, we: ex_we, wdata: ex_wdata, mem_op: ex_mem_op,
                    mem_addr: ex_mem_addr, mem_sdata: ex_mem_sdata};
        accept  = ex_valid && (sb.size() < 2);
        if (sb.size() != 0 && mem_ready) begin
          popped = sb.pop_front();
          if (sb.size() == 0) last_pay = popped;
        end
        if (accept) sb.push_back(cur_pay);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    set_pay('0);
    step(); step();
    rst = 1'b0;
    check_eq("rst_mem_valid", mem_valid, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_ex_ready", ex_ready, 1'b1);
    check_eq("rst_stall_cnt", stall_cnt, 16'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      ex_valid = 1'b1; set_pay(mk_pay(i));
      step();
      check_eq("t1_wdata", mem_wdata, i);
      check_eq("t1_valid", mem_valid, 1'b1);
      check_eq("t1_ready", ex_ready, 1'b1);
    end
    ex_valid = 1'b0; step();

    // Backpressure: A, B buffered, C held upstream.
    ex_valid = 1'b1; set_pay(mk_pay(32'hA)); mem_ready = 1'b1; step();
    set_pay(mk_pay(32'hB)); mem_ready = 1'b0; step();
    check_eq("t2_two_ready", ex_ready, 1'b0);
    check_eq("t2_two_wdata", mem_wdata, 32'hA);
    set_pay(mk_pay(32'hC)); step();
    check_eq("t2_hold_wdata", mem_wdata, 32'hA);
    mem_ready = 1'b1; step();
    check_eq("t2_b_wdata", mem_wdata, 32'hB);
    check_eq("t2_b_ready", ex_ready, 1'b1);
    step();
    check_eq("t2_c_wdata", mem_wdata, 32'hC);
    ex_valid = 1'b0; step();
    check_eq("t2_empty", mem_valid, 1'b0);

    // Flush in TWO with an incoming beat.
    ex_valid = 1'b1; set_pay(mk_pay(32'h1A)); mem_ready = 1'b1; step();
    set_pay(mk_pay(32'h1B)); mem_ready = 1'b0; step();
    set_pay(mk_pay(32'h1C)); flush = 1'b1; step();
    flush = 1'b0; ex_valid = 1'b0;
    check_eq("t3_valid", mem_valid, 1'b0);
    check_eq("t3_we", mem_we, 1'b0);
    check_eq("t3_ready", ex_ready, 1'b1);
    check_eq("t3_wdata", mem_wdata, 32'd0);
    mem_ready = 1'b1; step();
    check_eq("t3_still_empty", mem_valid, 1'b0);

    // Stall counter and saturation.
    rst = 1'b1; step(); rst = 1'b0;
    ex_valid = 1'b1; set_pay(mk_pay(32'h40)); mem_ready = 1'b1; step();
    ex_valid = 1'b0; mem_ready = 1'b0;
    repeat (5) step();
    check_eq("t4_stall5", stall_cnt, 16'd5);
    repeat (5) step();
    check_eq("t4_stall10", stall_cnt, 16'd10);
    check_eq("t4_sat", s_stall_cnt, 3'd7);
    flush = 1'b1; mem_ready = 1'b1; step(); flush = 1'b0;
    check_eq("t4_flush_keep", stall_cnt, 16'd10);
    check_eq("t4_flush_keep_sat", s_stall_cnt, 3'd7);

    // Reset while in TWO.
    rst = 1'b1; step(); rst = 1'b0;
    ex_valid = 1'b1; set_pay(mk_pay(32'h51)); mem_ready = 1'b1; step();
    set_pay(mk_pay(32'h52)); mem_ready = 1'b0; step();
    ex_valid = 1'b0; step(); step();
    check_eq("t5_stall3", stall_cnt, 16'd3);
    check_eq("t5_two", ex_ready, 1'b0);
    rst = 1'b1; ex_valid = 1'b1; set_pay(mk_pay(32'h53)); step();
    rst = 1'b0; ex_valid = 1'b0;
    check_eq("t5_valid", mem_valid, 1'b0);
    check_eq("t5_wdata", mem_wdata, 32'd0);
    check_eq("t5_ready", ex_ready, 1'b1);
    check_eq("t5_stall0", stall_cnt, 16'd0);
    mem_ready = 1'b1; step();
    check_eq("t5_dropped", mem_valid, 1'b0);

    // Randomized valid/ready/flush against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      ex_valid  = ($urandom_range(0, 3) != 0);
      set_pay(rand_pay());
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
